// File: rtl/clockvar_binding_multi.sv
`default_nettype none
// ============================================================================
// Module      : clockvar_binding_multi
// Description : Multi-channel pin binding block. Samples NUM_CH input buses
//               through an IN_SKEW-deep enabled register pipeline and drives
//               NUM_CH output buses from a valid/ready drive FSM. Each drive
//               is written after OUT_DELAY edges. It is then checked against
//               the sampled loopback value, with a TIMEOUT limit. Per-channel
//               sample-change pulses feed a saturating event counter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_in              in   clock, all state updates on posedge
//   rst_n               in   asynchronous active-low reset
//   in_data             in   raw channel inputs, channel c at [c*WIDTH +: WIDTH]
//   ch_en               in   per-channel sample enable
//   drv_valid           in   drive request
//   drv_ready           out  drive can be accepted (FSM idle)
//   drv_ch              in   target channel of the drive
//   drv_data            in   value to drive
//   clk_out_port        out  registered driven channel outputs
//   out_data_read_input out  sampled inputs (last skew stage)
//   sample_change       out  one-cycle pulse per channel on sampled change
//   change_cnt          out  saturating total of change events
//   chk_pass            out  one-cycle pulse: loopback matched
//   chk_fail            out  one-cycle pulse: timeout or bad channel
// ============================================================================
module clockvar_binding_multi #(
  parameter int WIDTH     = 8,
  parameter int NUM_CH    = 4,
  parameter int IN_SKEW   = 1,
  parameter int OUT_DELAY = 1,
  parameter int TIMEOUT   = 8,
  parameter int CNT_W     = 16,
  localparam int c_CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic                    drv_valid,
  output logic                    drv_ready,
  input  logic [c_CH_W-1:0]       drv_ch,
  input  logic [WIDTH-1:0]        drv_data,
  output logic [NUM_CH*WIDTH-1:0] clk_out_port,
  output logic [NUM_CH*WIDTH-1:0] out_data_read_input,
  output logic [NUM_CH-1:0]       sample_change,
  output logic [CNT_W-1:0]        change_cnt,
  output logic                    chk_pass,
  output logic                    chk_fail
);

  localparam int c_DLY_W = (OUT_DELAY > 1) ? $clog2(OUT_DELAY) : 1;
  localparam int c_TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_DLY_W-1:0] c_DLY_LOAD = c_DLY_W'(OUT_DELAY - 1);
  localparam logic [c_TMO_W-1:0] c_TMO_LOAD = c_TMO_W'(TIMEOUT - 1);
  localparam logic [c_CH_W:0]    c_NUM_CH   = (c_CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // Input skew pipeline
  // --------------------------------------------------------------------------
  logic [NUM_CH*WIDTH-1:0] r_skew [IN_SKEW];
  logic [NUM_CH*WIDTH-1:0] w_last;
  logic [NUM_CH*WIDTH-1:0] w_next_last;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < IN_SKEW; s++) begin
        r_skew[s] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_en[c]) begin
          r_skew[0][c*WIDTH +: WIDTH] <= in_data[c*WIDTH +: WIDTH];
          for (int s = 1; s < IN_SKEW; s++) begin
            r_skew[s][c*WIDTH +: WIDTH] <= r_skew[s-1][c*WIDTH +: WIDTH];
          end
        end
      end
    end
  end

  assign w_last              = r_skew[IN_SKEW-1];
  assign out_data_read_input = w_last;

  // Value the last stage will take on an enabled edge; used to detect a
  // change in the same edge that updates the last stage.
  generate
    if (IN_SKEW == 1) begin : g_skew_single
      assign w_next_last = in_data;
    end else begin : g_skew_multi
      assign w_next_last = r_skew[IN_SKEW-2];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Change detection and saturating counter
  // --------------------------------------------------------------------------
  logic [NUM_CH-1:0] r_change;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W:0]    w_pop;
  logic [CNT_W:0]    w_sum;

  always_comb begin
    w_pop = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      w_pop = w_pop + (CNT_W + 1)'(r_change[c]);
    end
  end

  // One spare carry bit flags overflow, which clamps to all-ones.
  assign w_sum = {1'b0, r_cnt} + w_pop;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_change <= '0;
      r_cnt    <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_change[c] <= ch_en[c] &&
                       (w_next_last[c*WIDTH +: WIDTH] != w_last[c*WIDTH +: WIDTH]);
      end
      r_cnt <= w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end
  end

  assign sample_change = r_change;
  assign change_cnt    = r_cnt;

  // --------------------------------------------------------------------------
  // Drive / check FSM
  // --------------------------------------------------------------------------
  state_t                  r_state;
  logic [c_CH_W-1:0]       r_ch;
  logic [WIDTH-1:0]        r_data;
  logic [c_DLY_W-1:0]      r_dcnt;
  logic [c_TMO_W-1:0]      r_tcnt;
  logic [NUM_CH*WIDTH-1:0] r_out;
  logic                    r_pass;
  logic                    r_fail;
  logic [WIDTH-1:0]        w_chk_val;
  logic                    w_ch_bad;

  // Sampled value of the channel under check.
  always_comb begin
    w_chk_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (r_ch == c_CH_W'(c)) begin
        w_chk_val = w_last[c*WIDTH +: WIDTH];
      end
    end
  end

  assign w_ch_bad = ({1'b0, drv_ch} >= c_NUM_CH);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_data  <= '0;
      r_dcnt  <= '0;
      r_tcnt  <= '0;
      r_out   <= '0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_pass <= 1'b0;
      r_fail <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (drv_valid) begin
            // Out-of-range requests are consumed and reported, nothing driven.
            if (w_ch_bad) begin
              r_fail <= 1'b1;
            end else begin
              r_ch    <= drv_ch;
              r_data  <= drv_data;
              r_dcnt  <= c_DLY_LOAD;
              r_state <= S_DRIVE;
            end
          end
        end
        S_DRIVE: begin
          if (r_dcnt == '0) begin
            for (int c = 0; c < NUM_CH; c++) begin
              if (r_ch == c_CH_W'(c)) begin
                r_out[c*WIDTH +: WIDTH] <= r_data;
              end
            end
            r_tcnt  <= c_TMO_LOAD;
            r_state <= S_CHECK;
          end else begin
            r_dcnt <= r_dcnt - c_DLY_W'(1);
          end
        end
        S_CHECK: begin
          // Match has priority so a match on the final cycle still passes.
          if (w_chk_val == r_data) begin
            r_pass  <= 1'b1;
            r_state <= S_IDLE;
          end else if (r_tcnt == '0) begin
            r_fail  <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt - c_TMO_W'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign drv_ready    = (r_state == S_IDLE);
  assign clk_out_port = r_out;
  assign chk_pass     = r_pass;
  assign chk_fail     = r_fail;

endmodule
`default_nettype wire

// File: tb/tb_clockvar_binding_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clockvar_binding_multi
// Description : Self-checking bench for clockvar_binding_multi with a
//               transaction-level reference model, a directed vector table,
//               hand sequences for drive/check corner cases and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clockvar_binding_multi;

  localparam int W    = 8;
  localparam int NCH  = 3;
  localparam int SKEW = 2;
  localparam int ODLY = 3;
  localparam int TMO  = 8;
  localparam int CW   = 4;
  localparam int CHW  = 2;
  localparam int CMAX = (1 << CW) - 1;
  localparam int HIST = 8192;

  logic              clk_in = 1'b0;
  logic              rst_n;
  logic [NCH*W-1:0]  in_data;
  logic [NCH-1:0]    ch_en;
  logic              drv_valid;
  logic              drv_ready;
  logic [CHW-1:0]    drv_ch;
  logic [W-1:0]      drv_data;
  logic [NCH*W-1:0]  clk_out_port;
  logic [NCH*W-1:0]  out_data_read_input;
  logic [NCH-1:0]    sample_change;
  logic [CW-1:0]     change_cnt;
  logic              chk_pass;
  logic              chk_fail;

  clockvar_binding_multi #(
    .WIDTH(W), .NUM_CH(NCH), .IN_SKEW(SKEW), .OUT_DELAY(ODLY),
    .TIMEOUT(TMO), .CNT_W(CW)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .in_data(in_data), .ch_en(ch_en),
    .drv_valid(drv_valid), .drv_ready(drv_ready), .drv_ch(drv_ch),
    .drv_data(drv_data), .clk_out_port(clk_out_port),
    .out_data_read_input(out_data_read_input), .sample_change(sample_change),
    .change_cnt(change_cnt), .chk_pass(chk_pass), .chk_fail(chk_fail)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: per-channel history of enabled samples, drive as a
  // transaction aged in edges since acceptance.
  // --------------------------------------------------------------------------
  logic [W-1:0] m_samp [NCH][HIST];
  int           m_n    [NCH];
  logic [W-1:0] m_out  [NCH];
  logic [NCH-1:0] m_chg;
  int           m_cnt;
  logic         m_pass, m_fail, m_busy;
  int           m_age, m_ch;
  logic [W-1:0] m_data;

  function automatic logic [W-1:0] m_read(input int c);
    if (m_n[c] >= SKEW) return m_samp[c][(m_n[c] - SKEW) % HIST];
    return '0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_n[c]   = 0;
      m_out[c] = '0;
    end
    m_chg = '0; m_cnt = 0; m_pass = 1'b0; m_fail = 1'b0;
    m_busy = 1'b0; m_age = 0; m_ch = 0; m_data = '0;
  endtask

  task automatic model_step();
    logic [W-1:0] old_rd [NCH];
    int pc;
    for (int c = 0; c < NCH; c++) old_rd[c] = m_read(c);
    pc = 0;
    for (int c = 0; c < NCH; c++) pc += int'(m_chg[c]);
    m_cnt  = (m_cnt + pc > CMAX) ? CMAX : m_cnt + pc;
    m_pass = 1'b0;
    m_fail = 1'b0;
    if (m_busy) begin
      m_age++;
      if (m_age == ODLY) begin
        m_out[m_ch] = m_data;
      end else if (m_age > ODLY) begin
        if (old_rd[m_ch] == m_data) begin
          m_pass = 1'b1; m_busy = 1'b0;
        end else if (m_age - ODLY == TMO) begin
          m_fail = 1'b1; m_busy = 1'b0;
        end
      end
    end else if (drv_valid) begin
      if (int'(drv_ch) >= NCH) begin
        m_fail = 1'b1;
      end else begin
        m_busy = 1'b1; m_age = 0; m_ch = int'(drv_ch); m_data = drv_data;
      end
    end
    for (int c = 0; c < NCH; c++) begin
      if (ch_en[c]) begin
        m_samp[c][m_n[c] % HIST] = in_data[c*W +: W];
        m_n[c]++;
        m_chg[c] = (m_read(c) != old_rd[c]);
      end else begin
        m_chg[c] = 1'b0;
      end
    end
  endtask

  task automatic model_check();
    logic [NCH*W-1:0] eo, er;
    for (int c = 0; c < NCH; c++) begin
      eo[c*W +: W] = m_out[c];
      er[c*W +: W] = m_read(c);
    end
    check("drv_ready", drv_ready, !m_busy);
    check("clk_out_port", clk_out_port, eo);
    check("read_input", out_data_read_input, er);
    check("sample_change", sample_change, m_chg);
    check("change_cnt", change_cnt, m_cnt[CW-1:0]);
    check("chk_pass", chk_pass, m_pass);
    check("chk_fail", chk_fail, m_fail);
  endtask

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  logic [NCH-1:0]   loop_mask;
  logic [NCH*W-1:0] base_in;

  task automatic tick();
    @(posedge clk_in);
    if (rst_n) model_step();
    #1;
    model_check();
  endtask

  // Apply inputs (looped channels follow the expected driven output), then clock.
  task automatic cyc();
    in_data = base_in;
    for (int c = 0; c < NCH; c++) if (loop_mask[c]) in_data[c*W +: W] = m_out[c];
    tick();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 4))
      0: return 8'h00;
      1: return 8'h5A;
      2: return 8'hA5;
      3: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  typedef struct {
    logic [NCH*W-1:0] in;
    logic [NCH-1:0]   en;
    logic [NCH*W-1:0] e_read;
    logic [NCH-1:0]   e_chg;
    logic [CW-1:0]    e_cnt;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int t_out, t_pass, t_fail, rdy_hi, pulses;

    tbl[0] = '{24'hA5A5A5, 3'b111, 24'h000000, 3'b000, 4'd0};
    tbl[1] = '{24'hA5A5A5, 3'b111, 24'hA5A5A5, 3'b111, 4'd0};
    tbl[2] = '{24'hA5A5A5, 3'b111, 24'hA5A5A5, 3'b000, 4'd3};
    tbl[3] = '{24'hA5A5A5, 3'b111, 24'hA5A5A5, 3'b000, 4'd3};
    tbl[4] = '{24'hA53CA5, 3'b001, 24'hA5A5A5, 3'b000, 4'd3};
    tbl[5] = '{24'hA53CA5, 3'b001, 24'hA5A5A5, 3'b000, 4'd3};
    tbl[6] = '{24'hA53CA5, 3'b111, 24'hA5A5A5, 3'b000, 4'd3};
    tbl[7] = '{24'hA53CA5, 3'b111, 24'hA53CA5, 3'b010, 4'd3};
    tbl[8] = '{24'hA53CA5, 3'b111, 24'hA53CA5, 3'b000, 4'd4};

    rst_n = 1'b0; model_reset();
    base_in = 24'hA5A5A5; loop_mask = '0; ch_en = 3'b111;
    drv_valid = 1'b0; drv_ch = '0; drv_data = '0; in_data = base_in;
    repeat (3) cyc();
    check("rst_read", out_data_read_input, 24'h0);
    check("rst_ready", drv_ready, 1'b1);
    check("rst_cnt", change_cnt, 4'd0);
    rst_n = 1'b1;

    // Directed sampling / change-detect table.
    for (int i = 0; i < 9; i++) begin
      base_in = tbl[i].in;
      ch_en   = tbl[i].en;
      cyc();
      check($sformatf("tbl%0d_read", i), out_data_read_input, tbl[i].e_read);
      check($sformatf("tbl%0d_chg", i), sample_change, tbl[i].e_chg);
      check($sformatf("tbl%0d_cnt", i), change_cnt, tbl[i].e_cnt);
    end

    // Loopback drive on ch2: write at edge 3, pass after SKEW+1 more edges.
    loop_mask = 3'b100; ch_en = 3'b111;
    drv_valid = 1'b1; drv_ch = 2'd2; drv_data = 8'h5A;
    cyc();
    drv_valid = 1'b0;
    check("lb_ready_low", drv_ready, 1'b0);
    t_out = -1; t_pass = -1; rdy_hi = 0;
    for (int n = 1; n <= 12; n++) begin
      cyc();
      if (t_out < 0 && clk_out_port[16 +: 8] == 8'h5A) t_out = n;
      if (t_pass < 0 && chk_pass) t_pass = n;
      if (t_pass < 0 && drv_ready) rdy_hi++;
    end
    check("lb_out_edge", t_out, 3);
    check("lb_pass_edge", t_pass, 6);
    check("lb_ready_busy", rdy_hi, 0);
    check("lb_ready_back", drv_ready, 1'b1);

    // Drive ch1 with its input tied to 0: timeout TMO edges after write.
    loop_mask = '0; base_in = 24'h5A00A5;
    drv_valid = 1'b1; drv_ch = 2'd1; drv_data = 8'hFF;
    cyc();
    drv_valid = 1'b0;
    t_fail = -1; t_pass = -1;
    for (int n = 1; n <= 15; n++) begin
      cyc();
      if (t_fail < 0 && chk_fail) t_fail = n;
      if (t_pass < 0 && chk_pass) t_pass = n;
    end
    check("to_fail_edge", t_fail, ODLY + TMO);
    check("to_no_pass", t_pass, -1);
    check("to_out_held", clk_out_port, 24'h5AFF00);

    // Out-of-range channel.
    drv_valid = 1'b1; drv_ch = 2'd3; drv_data = 8'h11;
    cyc();
    drv_valid = 1'b0;
    check("bad_fail", chk_fail, 1'b1);
    check("bad_ready", drv_ready, 1'b1);
    check("bad_out", clk_out_port, 24'h5AFF00);
    cyc();
    check("bad_fail_once", chk_fail, 1'b0);
    check("bad_ready2", drv_ready, 1'b1);

    // Counter saturation under repeated all-channel changes.
    ch_en = 3'b111;
    for (int i = 0; i < 12; i++) begin
      base_in = (i % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      cyc();
    end
    check("sat_cnt", change_cnt, 4'd15);
    for (int i = 0; i < 3; i++) begin
      base_in = (i % 2 == 1) ? 24'hFFFFFF : 24'h000000;
      cyc();
    end
    check("sat_hold", change_cnt, 4'd15);

    // Reset in the middle of DRIVE.
    base_in = 24'h000000;
    drv_valid = 1'b1; drv_ch = 2'd0; drv_data = 8'h77;
    cyc();
    drv_valid = 1'b0;
    cyc();
    #3;
    rst_n = 1'b0; model_reset();
    #1;
    check("mr_out", clk_out_port, 24'h0);
    check("mr_read", out_data_read_input, 24'h0);
    check("mr_cnt", change_cnt, 4'd0);
    check("mr_chg", sample_change, 3'b000);
    check("mr_ready", drv_ready, 1'b1);
    cyc(); cyc();
    rst_n = 1'b1;
    pulses = 0;
    for (int n = 0; n < 12; n++) begin
      cyc();
      if (chk_pass || chk_fail) pulses++;
    end
    check("mr_no_pulse", pulses, 0);
    check("mr_out_after", clk_out_port, 24'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0; model_reset();
      end else begin
        rst_n = 1'b1;
      end
      if (i % 40 == 0) loop_mask = 3'($urandom_range(0, 7));
      ch_en = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
      for (int c = 0; c < NCH; c++) base_in[c*W +: W] = pick();
      drv_valid = ($urandom_range(0, 3) == 0);
      drv_ch    = 2'($urandom);
      drv_data  = pick();
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clockvar_binding_multi.md
Name: clockvar_binding_multi

Overview:
- Multi-channel, parametrised successor of the single-bit clocking-block binding.
- Samples NUM_CH input buses through a configurable input-skew pipeline and drives NUM_CH output buses through a configurable output-delay pipeline.
- Adds a valid/ready drive handshake, loopback check with timeout, per-channel change detection and a saturating change counter.
- Sits at the boundary between testbench-style stimulus logic and the DUT pins of MiscExpressions blocks.

Parameters:
- WIDTH, 8, bits per channel.
- NUM_CH, 4, channel count (>=1).
- IN_SKEW, 1, input sampling register stages (>=1).
- OUT_DELAY, 1, edges from drive acceptance to output update (>=1).
- TIMEOUT, 8, CHECK-state cycles before fail (>=1).
- CNT_W, 16, change counter width.

Ports:
- clk_in  input  1  single clock; all state updates on posedge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  NUM_CH*WIDTH  raw channel inputs; channel c = bits [c*WIDTH +: WIDTH].
- ch_en  input  NUM_CH  per-channel sample enable.
- drv_valid  input  1  drive request.
- drv_ready  output  1  high when a drive can be accepted.
- drv_ch  input  max(1,$clog2(NUM_CH))  target channel.
- drv_data  input  WIDTH  value to drive.
- clk_out_port  output  NUM_CH*WIDTH  driven channel outputs (registered).
- out_data_read_input  output  NUM_CH*WIDTH  sampled inputs (final skew stage).
- sample_change  output  NUM_CH  one-cycle pulse per channel on sampled-value change.
- change_cnt  output  CNT_W  saturating total of change events.
- chk_pass  output  1  one-cycle pulse: loopback matched.
- chk_fail  output  1  one-cycle pulse: timeout or bad channel.

Behaviour:
- Reset (rst_n low, asynchronous): all skew stages, clk_out_port, out_data_read_input, sample_change, change_cnt, chk_pass and chk_fail go to 0. FSM goes to IDLE, so drv_ready=1. Any in-flight drive is discarded. Reset release takes effect on the next posedge.
- Sampling:
  - Stage 0 captures in_data[c] at each posedge when ch_en[c]=1 and holds when ch_en[c]=0.
  - Stages 1..IN_SKEW-1 shift under the same enable.
  - out_data_read_input is the last stage. Latency is IN_SKEW edges with enable continuously high.
- Change detect:
  - sample_change[c] is registered. It is 1 for exactly one cycle after an edge where channel c's last stage was updated (enable high) with a value different from its previous value.
  - change_cnt adds popcount(sample_change) each cycle and saturates at all-ones, with no wrap.
- Drive FSM, states IDLE, DRIVE, CHECK:
  - IDLE: drv_ready=1. On drv_valid&drv_ready, latch drv_ch/drv_data, load delay counter with OUT_DELAY-1, go to DRIVE. drv_ready is 0 in every other state.
  - IDLE, out-of-range channel (drv_ch>=NUM_CH): accept the request, leave outputs unchanged, pulse chk_fail next cycle, stay in IDLE.
  - DRIVE: decrement the counter each edge. On the edge where it is 0, write clk_out_port[latched ch]=latched data, load timeout counter with TIMEOUT-1, go to CHECK. The output therefore changes OUT_DELAY edges after the accepting edge.
  - CHECK: each cycle compare out_data_read_input[ch] with latched data.
    - Match: pulse chk_pass, go to IDLE.
    - Otherwise, on timeout counter 0: pulse chk_fail, go to IDLE.
    - Otherwise: decrement.
    - A match on the last allowed cycle counts as a pass.
    - A disabled channel is still checked and normally times out.
- Other channels' outputs hold their values indefinitely. drv_valid outside IDLE is ignored (no queueing).
- chk_pass and chk_fail are never high together.

Test Plan:
- Reset with in_data=all 0xA5, IN_SKEW=2, ch_en=4'hF: out_data_read_input=0 during reset; after release it reads 0xA5 per channel at the 2nd edge; sample_change=4'hF for one cycle; change_cnt=4.
- ch_en=4'b0001, toggle ch1 input 0x00→0x3C: ch1 sample holds 0; no change pulse on ch1; change_cnt unchanged.
- Drive ch2=0x5A with OUT_DELAY=3, in_data ch2 looped from clk_out_port ch2, IN_SKEW=1: drv_ready=0 for the DRIVE+CHECK interval; clk_out_port ch2=0x5A at the 3rd edge after acceptance; chk_pass pulses 2 cycles later; drv_ready returns to 1.
- Drive ch1=0xFF with ch1 input tied to 0, TIMEOUT=8: chk_fail pulses exactly 8 cycles after entering CHECK; clk_out_port ch1 stays 0xFF.
- NUM_CH=3, drv_ch=3: chk_fail pulses next cycle; clk_out_port unchanged; FSM never leaves IDLE.
- CNT_W=4 with repeated changes on all channels: change_cnt saturates at 15. Assert rst_n low mid-DRIVE: outputs go to 0 immediately, and no chk pulse appears after release.
